std_sram_64d128x_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of one `std_sram_singleport_64d128x` instance (64 entries × 128 bits, 1-cycle read latency). It lets two independent requesters share the single-port macro, for example an instruction-fetch refill path and a data/LSU path. It adds 16-byte write strobes on top of the unmasked SRAM, using a two-cycle read-modify-write (RMW) sequence for partial writes.

---
 rtl/std_sram_64d128x_pkg.sv | 15 +
 rtl/std_sram_singleport_64d128x.sv | 23 ++
 rtl/std_sram_64d128x_arbiter.sv | 147 ++++++++++++++
 tb/tb_std_sram_64d128x_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/std_sram_64d128x_pkg.sv
// Shared geometry constants and FSM state encoding for the 64x128 SRAM arbiter.
package std_sram_64d128x_pkg;

  localparam int unsigned SRAM_AW = 6;
  localparam int unsigned SRAM_DW = 128;
  localparam int unsigned SRAM_BW = 16;

  localparam logic [SRAM_BW-1:0] WSTRB_FULL = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

endpackage

// File: rtl/std_sram_singleport_64d128x.sv
// Behavioural single-port SRAM, 64 x 128 bits, 1-cycle read latency, unmasked writes.
module std_sram_singleport_64d128x
  import std_sram_64d128x_pkg::*;
(
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [SRAM_AW-1:0] addr,
  input  logic [SRAM_DW-1:0] din,
  output logic [SRAM_DW-1:0] dout
);

  logic [SRAM_DW-1:0] mem [0:(1 << SRAM_AW)-1];

  // Array write or registered read; dout holds its value across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/std_sram_64d128x_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 64x128 SRAM.
// Partial (byte-strobed) writes are performed as a read followed by a merged write.
module std_sram_64d128x_arbiter
  import std_sram_64d128x_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [SRAM_AW-1:0] req0_addr,
  input  logic [SRAM_DW-1:0] req0_wdata,
  input  logic [SRAM_BW-1:0] req0_wstrb,
  output logic               resp0_valid,
  output logic [SRAM_DW-1:0] resp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [SRAM_AW-1:0] req1_addr,
  input  logic [SRAM_DW-1:0] req1_wdata,
  input  logic [SRAM_BW-1:0] req1_wstrb,
  output logic               resp1_valid,
  output logic [SRAM_DW-1:0] resp1_rdata
);

  state_t             state;
  logic               last;
  logic [SRAM_AW-1:0] rmw_addr;
  logic [SRAM_DW-1:0] rmw_wdata;
  logic [SRAM_BW-1:0] rmw_wstrb;
  logic               rd_pend;
  logic               rd_port;

  logic               gnt_any;
  logic               gnt_port;
  logic               sel_we;
  logic [SRAM_AW-1:0] sel_addr;
  logic [SRAM_DW-1:0] sel_wdata;
  logic [SRAM_BW-1:0] sel_wstrb;
  logic               sel_partial;
  logic [SRAM_DW-1:0] merged;

  logic               sram_en;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_din;
  logic [SRAM_DW-1:0] sram_dout;

  // Round-robin grant: on conflict the port that did not win last time is chosen.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = 1'b0;
    if (resetn && state == ST_IDLE && (req0_valid || req1_valid)) begin
      gnt_any  = 1'b1;
      gnt_port = (req0_valid && req1_valid) ? ~last : req1_valid;
    end
  end

  assign req0_ready = gnt_any & ~gnt_port;
  assign req1_ready = gnt_any &  gnt_port;

  // Payload of the granted port.
  always_comb begin
    sel_we    = gnt_port ? req1_we    : req0_we;
    sel_addr  = gnt_port ? req1_addr  : req0_addr;
    sel_wdata = gnt_port ? req1_wdata : req0_wdata;
    sel_wstrb = gnt_port ? req1_wstrb : req0_wstrb;
    sel_partial = sel_we && (sel_wstrb != WSTRB_FULL) && (sel_wstrb != '0);
  end

  // Byte merge of the captured write data over the word read in the grant cycle.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < SRAM_BW; i++) begin
      merged[8*i +: 8] = rmw_wstrb[i] ? rmw_wdata[8*i +: 8] : sram_dout[8*i +: 8];
    end
  end

  // SRAM command; gated by resetn so a reset during RMW aborts the pending write.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = sel_addr;
    sram_din  = sel_wdata;
    if (resetn) begin
      if (state == ST_RMW) begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = rmw_addr;
        sram_din  = merged;
      end else if (gnt_any) begin
        if (!sel_we) begin
          sram_en = 1'b1;
        end else if (sel_wstrb == WSTRB_FULL) begin
          sram_en = 1'b1;
          sram_we = 1'b1;
        end else if (sel_wstrb != '0) begin
          sram_en = 1'b1;
        end
      end
    end
  end

  // FSM, round-robin pointer, RMW capture and read-response tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
      rmw_addr  <= '0;
      rmw_wdata <= '0;
      rmw_wstrb <= '0;
    end else begin
      rd_pend <= gnt_any & ~sel_we;
      rd_port <= gnt_port;
      if (gnt_any) last <= gnt_port;
      case (state)
        ST_IDLE: begin
          if (gnt_any && sel_partial) begin
            state     <= ST_RMW;
            rmw_addr  <= sel_addr;
            rmw_wdata <= sel_wdata;
            rmw_wstrb <= sel_wstrb;
          end
        end
        ST_RMW:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign resp0_valid = rd_pend & ~rd_port;
  assign resp1_valid = rd_pend &  rd_port;
  assign resp0_rdata = resp0_valid ? sram_dout : '0;
  assign resp1_rdata = resp1_valid ? sram_dout : '0;

  std_sram_singleport_64d128x u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .din  (sram_din),
    .dout (sram_dout)
  );

endmodule

// File: tb/tb_std_sram_64d128x_arbiter.sv
// Directed self-checking bench for std_sram_64d128x_arbiter.
module tb_std_sram_64d128x_arbiter;

  logic         clk;
  logic         resetn;
  logic         req0_valid, req0_ready, req0_we;
  logic [5:0]   req0_addr;
  logic [127:0] req0_wdata;
  logic [15:0]  req0_wstrb;
  logic         resp0_valid;
  logic [127:0] resp0_rdata;
  logic         req1_valid, req1_ready, req1_we;
  logic [5:0]   req1_addr;
  logic [127:0] req1_wdata;
  logic [15:0]  req1_wstrb;
  logic         resp1_valid;
  logic [127:0] resp1_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] D5   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1   = 128'h11111111111111111111111111111111;
  localparam logic [127:0] D2   = 128'h22222222222222222222222222222222;
  localparam logic [127:0] D3   = 128'h33333333333333333333333333333333;
  localparam logic [127:0] D7   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] DAA  = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [127:0] D55  = 128'h55555555555555555555555555555555;
  localparam logic [127:0] DMRG = 128'hAAAAAAAAAAAAAAAA55555555AAAAAAAA;
  localparam logic [127:0] DDEA = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  std_sram_64d128x_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_wstrb  (req0_wstrb),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_wstrb  (req1_wstrb),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven 1 time unit after the falling edge.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
  endtask

  task automatic drive0(input logic we, input logic [5:0] a, input logic [127:0] d, input logic [15:0] s);
    req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; req0_wstrb = s;
  endtask

  task automatic drive1(input logic we, input logic [5:0] a, input logic [127:0] d, input logic [15:0] s);
    req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; req1_wstrb = s;
  endtask

  task automatic preload(input logic [5:0] a, input logic [127:0] d);
    idle_all();
    drive0(1'b1, a, d, 16'hFFFF);
    #1 check("preload_ready0", req0_ready, 1'b1);
    next();
    idle_all();
    #1 check("write_no_resp0", resp0_valid, 1'b0);
  endtask

  initial begin
    idle_all();
    resetn = 1'b0;
    drive0(1'b0, 6'd0, '0, '0);
    drive1(1'b0, 6'd0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_resp0_valid", resp0_valid, 1'b0);
    check("rst_resp1_valid", resp1_valid, 1'b0);
    check("rst_resp0_rdata", resp0_rdata, '0);
    check("rst_resp1_rdata", resp1_rdata, '0);
    idle_all();
    resetn = 1'b1;
    next();

    preload(6'd5, D5);
    preload(6'd1, D1);
    preload(6'd2, D2);
    preload(6'd3, D3);
    preload(6'd9, DAA);
    preload(6'd7, D7);

    // Single read
    idle_all();
    drive0(1'b0, 6'd5, '0, '0);
    #1 check("rd_ready0", req0_ready, 1'b1);
    check("rd_ready1", req1_ready, 1'b0);
    check("rd_sram_en", dut.u_sram.en, 1'b1);
    next();
    idle_all();
    #1 check("rd_resp0_valid", resp0_valid, 1'b1);
    check("rd_resp0_rdata", resp0_rdata, D5);
    check("rd_resp1_valid", resp1_valid, 1'b0);

    // Zero-strobe write: accepted, SRAM untouched
    drive0(1'b1, 6'd3, 128'hFFFF0000FFFF0000FFFF0000FFFF0000, 16'h0000);
    #1 check("zs_ready0", req0_ready, 1'b1);
    check("zs_sram_en", dut.u_sram.en, 1'b0);
    next();
    idle_all();
    #1 check("zs_no_resp", resp0_valid, 1'b0);
    check("zs_idle_ready", req0_ready, 1'b0);
    drive0(1'b0, 6'd3, '0, '0);
    #1 check("zs_rd_ready0", req0_ready, 1'b1);
    next();
    idle_all();
    #1 check("zs_addr3_kept", resp0_rdata, D3);

    // Partial write by port 1, then both ports read the merged word
    drive1(1'b1, 6'd9, D55, 16'h00F0);
    #1 check("pw_ready1", req1_ready, 1'b1);
    next();
    idle_all();
    drive0(1'b0, 6'd9, '0, '0);
    drive1(1'b0, 6'd9, '0, '0);
    #1 check("pw_rmw_ready0", req0_ready, 1'b0);
    check("pw_rmw_ready1", req1_ready, 1'b0);
    next();
    #1 check("pw_next_ready0", req0_ready, 1'b1);
    check("pw_next_ready1", req1_ready, 1'b0);
    next();
    req0_valid = 1'b0;
    #1 check("pw_resp0_valid", resp0_valid, 1'b1);
    check("pw_resp0_rdata", resp0_rdata, DMRG);
    check("pw_ready1_after", req1_ready, 1'b1);
    next();
    idle_all();
    #1 check("pw_resp1_valid", resp1_valid, 1'b1);
    check("pw_resp1_rdata", resp1_rdata, DMRG);
    check("pw_resp0_quiet", resp0_valid, 1'b0);

    // Full write then immediate read from the other port
    drive0(1'b1, 6'd63, DDEA, 16'hFFFF);
    #1 check("fw_ready0", req0_ready, 1'b1);
    next();
    idle_all();
    drive1(1'b0, 6'd63, '0, '0);
    #1 check("fw_rd_ready1", req1_ready, 1'b1);
    check("fw_no_resp0", resp0_valid, 1'b0);
    next();
    idle_all();
    #1 check("fw_resp1_valid", resp1_valid, 1'b1);
    check("fw_resp1_rdata", resp1_rdata, DDEA);
    check("fw_resp0_valid", resp0_valid, 1'b0);

    // Reset in the RMW cycle of a partial write by port 0 (last becomes 0)
    drive0(1'b1, 6'd7, '1, 16'h0001);
    #1 check("rr_ready0", req0_ready, 1'b1);
    next();
    idle_all();
    resetn = 1'b0;
    #1 check("rr_rmw_ready0", req0_ready, 1'b0);
    next();
    resetn = 1'b1;
    #1 check("rr_ready0_zero", req0_ready, 1'b0);
    check("rr_ready1_zero", req1_ready, 1'b0);
    check("rr_resp0_valid", resp0_valid, 1'b0);
    check("rr_resp1_valid", resp1_valid, 1'b0);
    check("rr_resp0_rdata", resp0_rdata, '0);
    check("rr_resp1_rdata", resp1_rdata, '0);
    next();

    // Conflict rotation from reset: grants 0,1,0,1
    drive0(1'b0, 6'd1, '0, '0);
    drive1(1'b0, 6'd2, '0, '0);
    #1 check("cr_c0_ready0", req0_ready, 1'b1);
    check("cr_c0_ready1", req1_ready, 1'b0);
    next();
    #1 check("cr_c1_ready1", req1_ready, 1'b1);
    check("cr_c1_ready0", req0_ready, 1'b0);
    check("cr_c1_resp0", resp0_rdata, D1);
    check("cr_c1_resp1v", resp1_valid, 1'b0);
    next();
    #1 check("cr_c2_ready0", req0_ready, 1'b1);
    check("cr_c2_resp1", resp1_rdata, D2);
    check("cr_c2_resp0v", resp0_valid, 1'b0);
    next();
    #1 check("cr_c3_ready1", req1_ready, 1'b1);
    check("cr_c3_resp0v", resp0_valid, 1'b1);
    check("cr_c3_resp0", resp0_rdata, D1);
    next();
    idle_all();
    #1 check("cr_c4_resp1v", resp1_valid, 1'b1);
    check("cr_c4_resp1", resp1_rdata, D2);
    check("cr_c4_resp0v", resp0_valid, 1'b0);

    // Word hit by the aborted RMW keeps its old value
    drive1(1'b0, 6'd7, '0, '0);
    #1 check("rr_rd7_ready1", req1_ready, 1'b1);
    next();
    idle_all();
    #1 check("rr_addr7_kept", resp1_rdata, D7);
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
